// File: rtl/stack_cache_if.sv
// Request channel of the stack cache: valid/op/din from the requester,
// ready back from the stack. An op is taken on a clock where valid & ready.
interface stack_cache_if #(
    parameter int WIDTH = 16
);
    logic             valid;
    logic [1:0]       op;
    logic [WIDTH-1:0] din;
    logic             ready;

    modport master (
        output valid,
        output op,
        output din,
        input  ready
    );

    modport slave (
        input  valid,
        input  op,
        input  din,
        output ready
    );
endinterface

// File: rtl/stack_cache.sv
// Hardware stack: T and N live in flops, deeper entries spill to a
// synchronous-read RAM. The RAM holds count-2 entries, with its top at count-3.
// Ports: clock, nreset (async, active low), bus (valid/op/din/ready),
// clr_err, tos, nos, count, empty, full, overflow, underflow.
module stack_cache #(
    parameter int WIDTH = 16,
    parameter int AW    = 3
) (
    input  logic             clock,
    input  logic             nreset,
    stack_cache_if.slave     bus,
    input  logic             clr_err,
    output logic [WIDTH-1:0] tos,
    output logic [WIDTH-1:0] nos,
    output logic [AW+1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    localparam int CW    = AW + 2;
    localparam int DEPTH = 1 << AW;

    localparam logic [CW-1:0] CAP = CW'(DEPTH + 2);
    localparam logic [CW-1:0] C2  = CW'(2);
    localparam logic [CW-1:0] C3  = CW'(3);
    localparam logic [CW-1:0] C4  = CW'(4);

    localparam logic [1:0] OP_PUSH = 2'b01;
    localparam logic [1:0] OP_POP  = 2'b10;
    localparam logic [1:0] OP_REPL = 2'b11;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_FILL = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] tos_q, tos_d;
    logic [WIDTH-1:0] nos_q, nos_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_q;
    logic [AW-1:0]    wr_addr;
    logic [AW-1:0]    rd_addr;
    logic             we;

    logic ready;
    logic acc;
    logic is_push;
    logic is_pop;
    logic is_repl;
    logic is_empty;
    logic is_full;

    assign ready    = (state_q == S_IDLE);
    assign acc      = bus.valid & ready;
    assign is_push  = (bus.op == OP_PUSH);
    assign is_pop   = (bus.op == OP_POP);
    assign is_repl  = (bus.op == OP_REPL);
    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CAP);

    // Addresses wrap harmlessly below count 3; the RAM is only
    // written or consumed when enough entries exist.
    assign wr_addr = AW'(count_q - C2);
    assign rd_addr = AW'(count_q - C3);

    always_comb begin
        state_d = S_IDLE;
        count_d = count_q;
        tos_d   = tos_q;
        nos_d   = nos_q;
        ovf_d   = clr_err ? 1'b0 : ovf_q;
        unf_d   = clr_err ? 1'b0 : unf_q;
        we      = 1'b0;

        if (acc) begin
            unique case (1'b1)
                is_push: begin
                    if (is_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        we      = (count_q >= C2);
                        nos_d   = tos_q;
                        tos_d   = bus.din;
                        count_d = count_q + CW'(1);
                        if (count_q >= C2) state_d = S_FILL;
                    end
                end
                is_pop: begin
                    if (is_empty) begin
                        unf_d = 1'b1;
                    end else begin
                        tos_d   = nos_q;
                        nos_d   = (count_q >= C3) ? rd_q : '0;
                        count_d = count_q - CW'(1);
                        if (count_q >= C4) state_d = S_FILL;
                    end
                end
                is_repl: begin
                    if (is_empty) unf_d = 1'b1;
                    else          tos_d = bus.din;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            tos_q   <= '0;
            nos_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tos_q   <= tos_d;
            nos_q   <= nos_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Read runs every cycle at the current top; the FILL cycle after a
    // depth change lets rd_q catch up (including a just-written entry).
    always_ff @(posedge clock) begin
        if (we) mem[wr_addr] <= nos_q;
        rd_q <= mem[rd_addr];
    end

    assign bus.ready = ready;
    assign tos       = tos_q;
    assign nos       = nos_q;
    assign count     = count_q;
    assign empty     = is_empty;
    assign full      = is_full;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_stack_cache.sv
// Directed bench for stack_cache: vector table for single ops plus
// fill/drain, overflow and reset-during-refill sequences.
module tb_stack_cache;

    logic        clock;
    logic        nreset;
    logic        clr_err;
    logic [15:0] tos;
    logic [15:0] nos;
    logic [4:0]  count;
    logic        empty;
    logic        full;
    logic        overflow;
    logic        underflow;

    int total = 0;
    int bad   = 0;

    stack_cache_if #(.WIDTH(16)) bus ();

    stack_cache #(.WIDTH(16), .AW(3)) dut (
        .clock     (clock),
        .nreset    (nreset),
        .bus       (bus),
        .clr_err   (clr_err),
        .tos       (tos),
        .nos       (nos),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    typedef struct {
        logic        v;
        logic [1:0]  op;
        logic [15:0] din;
        logic        clr;
        logic [15:0] tos;
        logic [15:0] nos;
        logic [4:0]  cnt;
        logic        rdy;
        logic        ovf;
        logic        unf;
    } vec_t;

    vec_t tbl [13];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, a, e);
        end
    endtask

    // Waits (bounded) for ready, then holds the request for one clock.
    task automatic issue(input logic v, input logic [1:0] o,
                         input logic [15:0] d, input logic c);
        int n;
        n = 0;
        while (!bus.ready && n < 8) begin
            tick();
            n++;
        end
        if (!bus.ready) chk("ready_wait", {31'd0, bus.ready}, 32'd1);
        bus.valid = v;
        bus.op    = o;
        bus.din   = d;
        clr_err   = c;
        tick();
        bus.valid = 1'b0;
        bus.op    = 2'b00;
        bus.din   = 16'h0;
        clr_err   = 1'b0;
    endtask

    initial begin
        nreset    = 1'b0;
        bus.valid = 1'b0;
        bus.op    = 2'b00;
        bus.din   = 16'h0;
        clr_err   = 1'b0;

        //        v  op     din      clr tos      nos      cnt rdy ovf unf
        tbl[0]  = '{1, 2'b01, 16'h1111, 0, 16'h1111, 16'h0000, 1, 1, 0, 0};
        tbl[1]  = '{1, 2'b01, 16'h2222, 0, 16'h2222, 16'h1111, 2, 1, 0, 0};
        tbl[2]  = '{1, 2'b01, 16'h3333, 0, 16'h3333, 16'h2222, 3, 0, 0, 0};
        tbl[3]  = '{1, 2'b11, 16'hBEEF, 0, 16'hBEEF, 16'h2222, 3, 1, 0, 0};
        tbl[4]  = '{1, 2'b10, 16'h0000, 0, 16'h2222, 16'h1111, 2, 1, 0, 0};
        tbl[5]  = '{1, 2'b10, 16'h0000, 0, 16'h1111, 16'h0000, 1, 1, 0, 0};
        tbl[6]  = '{1, 2'b10, 16'h0000, 0, 16'h0000, 16'h0000, 0, 1, 0, 0};
        tbl[7]  = '{1, 2'b10, 16'h0000, 0, 16'h0000, 16'h0000, 0, 1, 0, 1};
        tbl[8]  = '{0, 2'b00, 16'h0000, 1, 16'h0000, 16'h0000, 0, 1, 0, 0};
        tbl[9]  = '{1, 2'b10, 16'h0000, 1, 16'h0000, 16'h0000, 0, 1, 0, 1};
        tbl[10] = '{0, 2'b00, 16'h0000, 1, 16'h0000, 16'h0000, 0, 1, 0, 0};
        tbl[11] = '{1, 2'b11, 16'hCAFE, 0, 16'h0000, 16'h0000, 0, 1, 0, 1};
        tbl[12] = '{1, 2'b00, 16'h7777, 1, 16'h0000, 16'h0000, 0, 1, 0, 0};

        repeat (2) tick();
        chk("rst_tos", {16'd0, tos}, 32'h0);
        chk("rst_cnt", {27'd0, count}, 32'd0);
        chk("rst_rdy", {31'd0, bus.ready}, 32'd1);
        nreset = 1'b1;
        tick();
        chk("init_tos", {16'd0, tos}, 32'h0);
        chk("init_nos", {16'd0, nos}, 32'h0);
        chk("init_cnt", {27'd0, count}, 32'd0);
        chk("init_rdy", {31'd0, bus.ready}, 32'd1);
        chk("init_empty", {31'd0, empty}, 32'd1);
        chk("init_full", {31'd0, full}, 32'd0);
        chk("init_ovf", {31'd0, overflow}, 32'd0);
        chk("init_unf", {31'd0, underflow}, 32'd0);

        for (int i = 0; i < 13; i++) begin
            issue(tbl[i].v, tbl[i].op, tbl[i].din, tbl[i].clr);
            chk($sformatf("row%0d_tos", i), {16'd0, tos}, {16'd0, tbl[i].tos});
            chk($sformatf("row%0d_nos", i), {16'd0, nos}, {16'd0, tbl[i].nos});
            chk($sformatf("row%0d_cnt", i), {27'd0, count},
                {27'd0, tbl[i].cnt});
            chk($sformatf("row%0d_rdy", i), {31'd0, bus.ready},
                {31'd0, tbl[i].rdy});
            chk($sformatf("row%0d_ovf", i), {31'd0, overflow},
                {31'd0, tbl[i].ovf});
            chk($sformatf("row%0d_unf", i), {31'd0, underflow},
                {31'd0, tbl[i].unf});
            chk($sformatf("row%0d_empty", i), {31'd0, empty},
                {31'd0, (tbl[i].cnt == 5'd0)});
        end

        // Fill to capacity, then one push too many.
        for (int k = 1; k <= 10; k++) begin
            issue(1'b1, 2'b01, 16'(k), 1'b0);
            chk($sformatf("fill%0d_tos", k), {16'd0, tos}, k);
            chk($sformatf("fill%0d_rdy", k), {31'd0, bus.ready},
                (k >= 3) ? 32'd0 : 32'd1);
        end
        tick();
        chk("full_flag", {31'd0, full}, 32'd1);
        chk("full_nos", {16'd0, nos}, 32'h9);
        chk("full_cnt", {27'd0, count}, 32'd10);
        issue(1'b1, 2'b01, 16'hDEAD, 1'b0);
        chk("ovf_flag", {31'd0, overflow}, 32'd1);
        chk("ovf_tos", {16'd0, tos}, 32'hA);
        chk("ovf_cnt", {27'd0, count}, 32'd10);
        chk("ovf_rdy", {31'd0, bus.ready}, 32'd1);
        issue(1'b0, 2'b00, 16'h0, 1'b1);
        chk("ovf_clr", {31'd0, overflow}, 32'd0);

        // Drain: exercises every RAM read-back.
        for (int k = 1; k <= 10; k++) begin
            issue(1'b1, 2'b10, 16'h0, 1'b0);
            chk($sformatf("pop%0d_tos", k), {16'd0, tos}, 10 - k);
            chk($sformatf("pop%0d_nos", k), {16'd0, nos},
                (k >= 9) ? 0 : 9 - k);
            chk($sformatf("pop%0d_cnt", k), {27'd0, count}, 10 - k);
            chk($sformatf("pop%0d_rdy", k), {31'd0, bus.ready},
                (10 - k >= 3) ? 32'd0 : 32'd1);
        end
        chk("drain_empty", {31'd0, empty}, 32'd1);

        // Request held while ready is low must not be taken early.
        issue(1'b1, 2'b01, 16'h00A1, 1'b0);
        issue(1'b1, 2'b01, 16'h00A2, 1'b0);
        issue(1'b1, 2'b01, 16'h00A3, 1'b0);
        chk("fill_rdy", {31'd0, bus.ready}, 32'd0);
        bus.valid = 1'b1;
        bus.op    = 2'b01;
        bus.din   = 16'h00A4;
        tick();
        chk("held_cnt", {27'd0, count}, 32'd3);
        chk("held_tos", {16'd0, tos}, 32'hA3);
        tick();
        bus.valid = 1'b0;
        bus.op    = 2'b00;
        chk("taken_cnt", {27'd0, count}, 32'd4);
        chk("taken_tos", {16'd0, tos}, 32'hA4);
        chk("taken_nos", {16'd0, nos}, 32'hA3);

        // Reset asserted in the FILL cycle.
        chk("pre_rst_rdy", {31'd0, bus.ready}, 32'd0);
        nreset = 1'b0;
        #1;
        chk("frst_cnt", {27'd0, count}, 32'd0);
        chk("frst_rdy", {31'd0, bus.ready}, 32'd1);
        chk("frst_tos", {16'd0, tos}, 32'h0);
        chk("frst_nos", {16'd0, nos}, 32'h0);
        @(negedge clock);
        nreset = 1'b1;
        issue(1'b1, 2'b01, 16'h0055, 1'b0);
        chk("post_tos", {16'd0, tos}, 32'h55);
        chk("post_cnt", {27'd0, count}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
